demux_4_32_buf: RTL and testbench
=================================

DEMUX_4_32_BUF -- requirements
Module: demux_4_32_buf

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port data_in, input, 32 bits: word to route.
REQ-004 The block SHALL have port select, input, 2 bits: destination channel 0..3 for data_in.
REQ-005 The block SHALL have port enable, input, 1 bit: global accept enable.
REQ-006 The block SHALL have port in_valid, input, 1 bit: data_in/select are valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts the word this cycle.
REQ-008 The block SHALL have ports data_out_0..data_out_3, output, 32 bits each: per-channel held word.
REQ-009 The block SHALL have port out_valid, output, 4 bits: bit n set means data_out_n holds an undelivered word.
REQ-010 The block SHALL have port out_ready, input, 4 bits: bit n set means the channel n consumer takes the word this cycle.
REQ-011 The block SHALL have ports count_0..count_3, output, 16 bits each: per-channel delivered-word counters (see Configuration).

Function
REQ-012 Each channel SHALL be a two-state machine: EMPTY (out_valid[n]=0) and FULL (out_valid[n]=1).
REQ-013 in_ready SHALL be combinational: enable AND (out_valid[select]=0 OR out_ready[select]=1).
REQ-014 Accept SHALL occur when in_valid AND in_ready; select is sampled only at accept.
REQ-015 On accept, data_out_[select] SHALL load data_in at the next edge and out_valid[select] SHALL be 1 after that edge; the latency from input to output is 1 cycle.
REQ-016 Delivery on channel n SHALL occur when out_valid[n] AND out_ready[n].
REQ-017 On delivery with no accept to the same channel, channel n SHALL go FULL->EMPTY at the next edge.
REQ-018 On simultaneous delivery and accept on the same channel, the channel SHALL stay FULL with the new word loaded, sustaining one word per cycle.
REQ-019 Accepts to one channel SHALL be independent of deliveries on the other channels.
REQ-020 data_out_n SHALL hold its last loaded value while EMPTY; it SHALL NOT change except on accept to channel n.
REQ-021 enable=0 SHALL force in_ready=0 and SHALL NOT block deliveries on any channel.
REQ-022 out_ready on an EMPTY channel SHALL be ignored.
REQ-023 in_valid=0 SHALL cause no state change, regardless of the select value.

Reset
REQ-024 While rst=1 at a clock edge: out_valid SHALL be 4'b0000, all data_out_n SHALL be 32'h0, and all count_n SHALL be 16'h0.
REQ-025 in_ready SHALL be 0 during any cycle in which rst=1.
REQ-026 Reset mid-operation SHALL discard held words without delivery.
REQ-027 Reset mid-operation SHALL NOT count the accept of the reset cycle.

Configuration
REQ-028 The macro DEMUX_STATS_EN SHALL control the delivery counters.
REQ-029 When DEMUX_STATS_EN is defined, count_n SHALL increment by 1 on each delivery on channel n.
REQ-030 When DEMUX_STATS_EN is defined, count_n SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-031 When DEMUX_STATS_EN is not defined, count_0..count_3 SHALL remain as ports, tied to 16'h0, with no counter logic.

Verification
REQ-032 The bench SHALL cover: reset, then data_in=32'hA5A5_0001, select=2, in_valid=1, out_ready=0 -> next cycle out_valid=4'b0100 and data_out_2=32'hA5A5_0001.
REQ-033 The bench SHALL cover: channel 1 FULL with out_ready[1]=0 and a new word to select=1 -> in_ready=0; a word to select=3 in the same state -> accepted.
REQ-034 The bench SHALL cover: channel 0 FULL, out_ready[0]=1, in_valid=1, select=0, data_in=32'h0000_0002 -> channel stays FULL with data_out_0=32'h0000_0002 and 1 delivery counted.
REQ-035 The bench SHALL cover: enable=0 with in_valid=1 -> in_ready=0; a pending channel 3 word with out_ready[3]=1 is still delivered.
REQ-036 The bench SHALL cover: rst pulsed while out_valid=4'b1111 -> out_valid=0, all data_out=0, all count=0 the next cycle.
REQ-037 The bench SHALL cover, with DEMUX_STATS_EN defined: 65,537 deliveries on channel 0 -> count_0=16'hFFFF; without the macro -> count_0 stays 0.

Source files
------------

// File: rtl/demux_4_32_buf.sv
// demux_4_32_buf: routes a 32-bit word to one of four single-entry output channels.
// Ports: clk/rst (sync, active-high); data_in/select/in_valid/enable -> in_ready (input side);
// data_out_0..3/out_valid <- out_ready (per-channel output side); count_0..3 delivery counters.
// Macro DEMUX_STATS_EN enables the saturating delivery counters; otherwise counts are tied to 0.
module demux_4_32_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [1:0]  select,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] data_out_0,
  output logic [31:0] data_out_1,
  output logic [31:0] data_out_2,
  output logic [31:0] data_out_3,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [15:0] count_0,
  output logic [15:0] count_1,
  output logic [15:0] count_2,
  output logic [15:0] count_3
);
  logic [31:0] r_data [4];
  logic [3:0]  r_valid;
  logic [3:0]  w_dlv;
  logic        w_acc;
  // a FULL channel can still accept when its consumer drains it in the same cycle
  always_comb begin
    in_ready = ~rst & enable & (~r_valid[select] | out_ready[select]);
    w_acc    = in_valid & in_ready;
    w_dlv    = r_valid & out_ready;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= '0;
      for (int n = 0; n < 4; n++) r_data[n] <= '0;
    end else
      for (int n = 0; n < 4; n++)
        if (w_acc && select == 2'(n)) begin
          r_data[n]  <= data_in;
          r_valid[n] <= 1'b1;
        end else if (w_dlv[n])
          r_valid[n] <= 1'b0;
  assign out_valid  = r_valid;
  assign data_out_0 = r_data[0];
  assign data_out_1 = r_data[1];
  assign data_out_2 = r_data[2];
  assign data_out_3 = r_data[3];
`ifdef DEMUX_STATS_EN
  logic [15:0] r_cnt [4];
  always_ff @(posedge clk)
    for (int n = 0; n < 4; n++)
      if (rst) r_cnt[n] <= '0;
      else if (w_dlv[n] && r_cnt[n] != 16'hFFFF) r_cnt[n] <= r_cnt[n] + 16'd1;
  assign count_0 = r_cnt[0];
  assign count_1 = r_cnt[1];
  assign count_2 = r_cnt[2];
  assign count_3 = r_cnt[3];
`else
  assign count_0 = '0;
  assign count_1 = '0;
  assign count_2 = '0;
  assign count_3 = '0;
`endif
endmodule

// File: tb/tb_demux_4_32_buf.sv
// tb_demux_4_32_buf: scoreboard bench for demux_4_32_buf with directed and random traffic.
module tb_demux_4_32_buf;
`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [1:0]  select = '0;
  logic        enable = 1'b1;
  logic        in_valid = 1'b1;
  logic        in_ready;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [15:0] count_0, count_1, count_2, count_3;
  int checks = 0;
  int errors = 0;
  logic [31:0] q [4][$];
  logic [31:0] exp_data [4];
  int          exp_cnt [4];
  logic [31:0] dout [4];
  logic [15:0] cnt [4];
  demux_4_32_buf dut (
    .clk(clk), .rst(rst), .data_in(data_in), .select(select), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .count_0(count_0), .count_1(count_1), .count_2(count_2), .count_3(count_3)
  );
  always #5 clk = ~clk;
  always_comb begin
    dout = '{data_out_0, data_out_1, data_out_2, data_out_3};
    cnt  = '{count_0, count_1, count_2, count_3};
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial
    for (int n = 0; n < 4; n++) begin
      exp_data[n] = '0;
      exp_cnt[n]  = 0;
    end
  // Monitor: the model's channel occupancy is the scoreboard queue depth (0 = EMPTY, 1 = FULL).
  always @(negedge clk) begin
    logic       er;
    logic [3:0] ev;
    for (int n = 0; n < 4; n++) ev[n] = q[n].size() != 0;
    chk("out_valid", 64'(out_valid), 64'(ev));
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("data_out_%0d", n), 64'(dout[n]), 64'(exp_data[n]));
      chk($sformatf("count_%0d", n), 64'(cnt[n]), 64'(exp_cnt[n]));
    end
    er = !rst && enable && (q[select].size() == 0 || out_ready[select]);
    chk("in_ready", 64'(in_ready), 64'(er));
    if (rst)
      for (int n = 0; n < 4; n++) begin
        q[n].delete();
        exp_data[n] = '0;
        exp_cnt[n]  = 0;
      end
    else begin
      for (int n = 0; n < 4; n++)
        if (q[n].size() != 0 && out_ready[n]) begin
          chk($sformatf("deliver_%0d", n), 64'(dout[n]), 64'(q[n].pop_front()));
          if (STATS && exp_cnt[n] < 65535) exp_cnt[n]++;
        end
      if (in_valid && er) begin
        q[select].push_back(data_in);
        exp_data[select] = data_in;
      end
    end
  end
  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_data_out_2", 64'(data_out_2), 64'h0);
    chk("rst_count_0", 64'(count_0), 64'h0);
    data_in = 32'hA5A5_0001; select = 2'd2; in_valid = 1'b1; out_ready = 4'b0000;
    cyc();
    chk("first_out_valid", 64'(out_valid), 64'h4);
    chk("first_data_out_2", 64'(data_out_2), 64'hA5A5_0001);
    data_in = 32'h0000_0011; select = 2'd1;
    cyc();
    data_in = 32'h0000_0012; select = 2'd1;
    #1 chk("full_ch1_in_ready", 64'(in_ready), 64'h0);
    data_in = 32'h0000_0033; select = 2'd3;
    #1 chk("other_ch3_in_ready", 64'(in_ready), 64'h1);
    cyc();
    chk("ch13_out_valid", 64'(out_valid), 64'hE);
    chk("ch1_held", 64'(data_out_1), 64'h11);
    chk("ch3_loaded", 64'(data_out_3), 64'h33);
    data_in = 32'h0000_0001; select = 2'd0;
    cyc();
    data_in = 32'h0000_0002; out_ready = 4'b0001;
    #1 chk("pass_ch0_in_ready", 64'(in_ready), 64'h1);
    cyc();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("pass_ch0_valid", 64'(out_valid[0]), 64'h1);
    chk("pass_ch0_data", 64'(data_out_0), 64'h2);
    chk("pass_ch0_count", 64'(count_0), STATS ? 64'h1 : 64'h0);
    enable = 1'b0; in_valid = 1'b1; select = 2'd2; out_ready = 4'b1000;
    #1 chk("disabled_in_ready", 64'(in_ready), 64'h0);
    cyc();
    chk("disabled_ch3_delivered", 64'(out_valid), 64'h7);
    enable = 1'b1; out_ready = 4'b0000; select = 2'd3; data_in = 32'h0000_0034;
    cyc();
    in_valid = 1'b0;
    chk("all_full", 64'(out_valid), 64'hF);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_data_out_0", 64'(data_out_0), 64'h0);
    chk("midrst_data_out_3", 64'(data_out_3), 64'h0);
    chk("midrst_count_0", 64'(count_0), 64'h0);
    for (int i = 0; i < 3000; i++) begin
      data_in   = $urandom;
      select    = 2'($urandom_range(0, 3));
      in_valid  = $urandom_range(0, 3) != 0;
      enable    = $urandom_range(0, 7) != 0;
      out_ready = 4'($urandom);
      rst       = $urandom_range(0, 199) == 0;
      cyc();
    end
    rst = 1'b1; in_valid = 1'b1; enable = 1'b1; select = 2'd0; out_ready = 4'b0001;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < (STATS ? 65540 : 300); i++) begin
      data_in = $urandom;
      cyc();
    end
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("sat_count_0", 64'(count_0), STATS ? 64'hFFFF : 64'h0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
